bkm_control_sequencer: RTL and testbench
========================================

Name: bkm_control_sequencer

Overview:
- Iteration sequencer for the bkm_control_step datapath.
- Accepts an initial (u_0, v_0) pair and drives step index n to the combinational step.
- Feeds each registered (u_np1, v_np1) back as the next (u_n, v_n) for N_ITER iterations.
- Presents the final pair on a valid/ready result handshake. Sits between the FPU BKM top-level control and the step datapath.

Parameters:
- W, 64, datapath word width of u and v.
- N_ITER, 32, number of BKM iterations per operation; legal range 1 to 2**CNT_W.
- CNT_W, 6, width of step index n.

Ports:
- clk  in  1  clock, rising edge.
- arst  in  1  reset, asynchronous, active-high.
- enable  in  1  clock enable; when 0, all registers hold (arst still acts).
- abort  in  1  synchronous abort; returns to IDLE.
- start  in  1  operation request, sampled only when accepted (see Behaviour).
- u_0  in  W  initial u, captured on start accept.
- v_0  in  W  initial v, captured on start accept.
- cs_u_n  out  W  current u to step datapath.
- cs_v_n  out  W  current v to step datapath.
- cs_n  out  CNT_W  current step index to datapath.
- cs_u_np1  in  W  next u from step datapath (combinational from cs_*).
- cs_v_np1  in  W  next v from step datapath.
- busy  out  1  high in ITER.
- out_valid  out  1  final result valid.
- out_ready  in  1  consumer accepts result.
- u_fin  out  W  final u.
- v_fin  out  W  final v.
- iter_cnt  out  CNT_W+1  number of iterations executed for the current result.

Behaviour:
- Reset (arst=1): state IDLE. cs_u_n, cs_v_n, cs_n, u_fin, v_fin and iter_cnt are 0; busy and out_valid are 0.
- All state changes happen only on clk edges with enable=1. With enable=0 every register holds.
- States: IDLE, ITER, DONE.
- IDLE:
  - start=1 -> capture u_0/v_0 into cs_u_n/cs_v_n, set cs_n=0, go to ITER.
  - start=0 -> stay in IDLE.
- ITER:
  - Each enabled edge: cs_u_n<=cs_u_np1, cs_v_n<=cs_v_np1, cs_n<=cs_n+1.
  - On the edge where cs_n==N_ITER-1: also set u_fin<=cs_u_np1, v_fin<=cs_v_np1, iter_cnt<=N_ITER, go to DONE.
  - cs_n never wraps; with N_ITER==2**CNT_W the exit compare occurs at all-ones.
- DONE:
  - out_valid=1; u_fin, v_fin and iter_cnt are stable while out_valid=1 and out_ready=0.
  - out_ready=1, start=0 -> IDLE.
  - out_ready=1, start=1 -> result consumed and new operand loaded in the same edge; go to ITER with cs_n=0 (back-to-back operation).
  - out_ready=0 -> hold regardless of start.
- start is ignored in ITER, and in DONE without out_ready; no request queuing.
- Latency: first ITER cycle follows the start edge. out_valid rises exactly N_ITER enabled edges after the start-accept edge. Throughput is one result per N_ITER+1 cycles when out_ready is held high.
- abort=1 in any state:
  - next state IDLE, busy=0, out_valid=0, cs_n=0.
  - u_fin, v_fin and iter_cnt keep their last values.
  - abort has priority over start and out_ready on the same edge.
- cs_u_n and cs_v_n hold their last values in IDLE and DONE; they are not cleared.
- Arithmetic: the block performs no arithmetic on u/v. The only addition is the cs_n increment, which is unsigned and modulo-free by construction.
- arst mid-operation: immediate return to reset values; no result produced.

Optional Feature:
- Macro: BKM_SEQ_EARLY_EXIT_EN.
- Defined: in ITER, if cs_u_np1==cs_u_n and cs_v_np1==cs_v_n (fixed point reached), that edge behaves as the final iteration:
  - u_fin/v_fin are loaded and the state goes to DONE.
  - iter_cnt = cs_n+1.
  - The N_ITER limit still applies.
- Undefined: always exactly N_ITER iterations; iter_cnt is always N_ITER.

Test Plan:
- Datapath model u_np1=u_n+1, v_np1=v_n-1, u_0=100, v_0=200, N_ITER=32, out_ready=1 -> out_valid rises 32 edges after start; u_fin=132, v_fin=168, iter_cnt=32; busy high for exactly 32 cycles.
- Same model, out_ready=0 for 10 cycles after out_valid -> u_fin/v_fin stable at 132/168 throughout. start pulses during ITER and during the DONE stall are ignored.
- Back-to-back: hold start=1 and out_ready=1 with u_0=0, v_0=0, then u_0=5, v_0=5 -> second out_valid 33 cycles after the first; results 32/-32, then 37/-27.
- abort asserted at cs_n=7, together with start=1 -> IDLE next edge, out_valid never asserts, cs_n=0. A subsequent start completes normally.
- enable low for 5 cycles mid-ITER -> cs_n and cs_u_n frozen; out_valid delayed by exactly 5 cycles; values unchanged. arst pulse at cs_n=20 -> all outputs 0 immediately.
- BKM_SEQ_EARLY_EXIT_EN defined, model u_np1=u_n and v_np1=v_n from n>=3 -> DONE after 4 iterations, iter_cnt=4. Macro undefined -> iter_cnt=32.

Source files
------------

// File: rtl/bkm_control_sequencer.sv
// Iteration sequencer for the BKM step datapath: loads (u_0, v_0), loops the registered step
// outputs back for N_ITER steps, and presents the final pair on a valid/ready handshake.
// Optional macro BKM_SEQ_EARLY_EXIT_EN: finish early once the step reaches a fixed point.
module bkm_control_sequencer #(
  parameter int unsigned W      = 64,
  parameter int unsigned N_ITER = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             enable,
  input  logic             abort,
  input  logic             start,
  input  logic [W-1:0]     u_0,
  input  logic [W-1:0]     v_0,
  output logic [W-1:0]     cs_u_n,
  output logic [W-1:0]     cs_v_n,
  output logic [CNT_W-1:0] cs_n,
  input  logic [W-1:0]     cs_u_np1,
  input  logic [W-1:0]     cs_v_np1,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     u_fin,
  output logic [W-1:0]     v_fin,
  output logic [CNT_W:0]   iter_cnt
);

  typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

  localparam logic [CNT_W-1:0] LP_LAST      = CNT_W'(N_ITER - 1);
  localparam logic [CNT_W-1:0] LP_CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   LP_ITER_CNT  = (CNT_W + 1)'(N_ITER);

  state_e           r_state;
  logic [W-1:0]     r_cs_u_n;
  logic [W-1:0]     r_cs_v_n;
  logic [CNT_W-1:0] r_cs_n;
  logic             r_busy;
  logic             r_out_valid;
  logic [W-1:0]     r_u_fin;
  logic [W-1:0]     r_v_fin;
  logic [CNT_W:0]   r_iter_cnt;

  logic             w_last;
  logic             w_fixed;
  logic             w_exit;
  logic [CNT_W-1:0] w_cs_n_inc;
  logic [CNT_W:0]   w_fin_cnt;

  assign w_last = (r_cs_n == LP_LAST);

`ifdef BKM_SEQ_EARLY_EXIT_EN
  assign w_fixed   = (cs_u_np1 == r_cs_u_n) && (cs_v_np1 == r_cs_v_n);
  assign w_fin_cnt = {1'b0, r_cs_n} + (CNT_W + 1)'(1);
`else
  assign w_fixed   = 1'b0;
  assign w_fin_cnt = LP_ITER_CNT;
`endif

  assign w_exit = w_last || w_fixed;

  // Saturate so the index never wraps when N_ITER == 2**CNT_W.
  assign w_cs_n_inc = (r_cs_n == LP_CNT_MAX) ? r_cs_n : r_cs_n + CNT_W'(1);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state     <= StIdle;
      r_cs_u_n    <= '0;
      r_cs_v_n    <= '0;
      r_cs_n      <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_u_fin     <= '0;
      r_v_fin     <= '0;
      r_iter_cnt  <= '0;
    end else if (enable) begin
      if (abort) begin
        // Results from a previous operation stay visible on u_fin/v_fin/iter_cnt.
        r_state     <= StIdle;
        r_busy      <= 1'b0;
        r_out_valid <= 1'b0;
        r_cs_n      <= '0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (start) begin
              r_cs_u_n <= u_0;
              r_cs_v_n <= v_0;
              r_cs_n   <= '0;
              r_busy   <= 1'b1;
              r_state  <= StIter;
            end
          end
          StIter: begin
            r_cs_u_n <= cs_u_np1;
            r_cs_v_n <= cs_v_np1;
            r_cs_n   <= w_cs_n_inc;
            if (w_exit) begin
              r_u_fin     <= cs_u_np1;
              r_v_fin     <= cs_v_np1;
              r_iter_cnt  <= w_fin_cnt;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= StDone;
            end
          end
          StDone: begin
            if (out_ready) begin
              r_out_valid <= 1'b0;
              if (start) begin
                r_cs_u_n <= u_0;
                r_cs_v_n <= v_0;
                r_cs_n   <= '0;
                r_busy   <= 1'b1;
                r_state  <= StIter;
              end else begin
                r_state  <= StIdle;
              end
            end
          end
          default: begin
            r_state     <= StIdle;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cs_u_n    = r_cs_u_n;
  assign cs_v_n    = r_cs_v_n;
  assign cs_n      = r_cs_n;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign u_fin     = r_u_fin;
  assign v_fin     = r_v_fin;
  assign iter_cnt  = r_iter_cnt;

endmodule

// File: tb/tb_bkm_control_sequencer.sv
// Self-checking bench for bkm_control_sequencer with a +1/-1 step model and a result scoreboard.
module tb_bkm_control_sequencer;

  localparam int unsigned W  = 64;
  localparam int unsigned N  = 32;
  localparam int unsigned CW = 6;

  typedef struct {
    logic [W-1:0] u;
    logic [W-1:0] v;
    logic [CW:0]  cnt;
  } res_t;

  logic          clk = 1'b0;
  logic          arst;
  logic          enable;
  logic          abort;
  logic          start;
  logic [W-1:0]  u_0;
  logic [W-1:0]  v_0;
  logic [W-1:0]  cs_u_n;
  logic [W-1:0]  cs_v_n;
  logic [CW-1:0] cs_n;
  logic [W-1:0]  cs_u_np1;
  logic [W-1:0]  cs_v_np1;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  u_fin;
  logic [W-1:0]  v_fin;
  logic [CW:0]   iter_cnt;
  logic          fixed_mode;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  bkm_control_sequencer #(.W(W), .N_ITER(N), .CNT_W(CW)) dut (
    .clk      (clk),
    .arst     (arst),
    .enable   (enable),
    .abort    (abort),
    .start    (start),
    .u_0      (u_0),
    .v_0      (v_0),
    .cs_u_n   (cs_u_n),
    .cs_v_n   (cs_v_n),
    .cs_n     (cs_n),
    .cs_u_np1 (cs_u_np1),
    .cs_v_np1 (cs_v_np1),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .u_fin    (u_fin),
    .v_fin    (v_fin),
    .iter_cnt (iter_cnt)
  );

  always #5 clk = ~clk;

  // Step datapath model; fixed_mode freezes the pair from n>=3.
  assign cs_u_np1 = (fixed_mode && cs_n >= CW'(3)) ? cs_u_n : cs_u_n + 64'd1;
  assign cs_v_np1 = (fixed_mode && cs_n >= CW'(3)) ? cs_v_n : cs_v_n - 64'd1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] u, input logic [W-1:0] v, input logic [CW:0] c);
    res_t r;
    r.u = u;
    r.v = v;
    r.cnt = c;
    exp_q.push_back(r);
  endtask

  task automatic wait_valid(output int cyc, output int bcnt);
    cyc = 0;
    bcnt = 0;
    while (!out_valid && cyc < 200) begin
      if (busy) bcnt++;
      step();
      cyc++;
    end
    chk("valid_timeout", 128'(out_valid), 128'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cs_u_n"}, 128'(cs_u_n), 128'd0);
    chk({tag, "_cs_v_n"}, 128'(cs_v_n), 128'd0);
    chk({tag, "_cs_n"}, 128'(cs_n), 128'd0);
    chk({tag, "_u_fin"}, 128'(u_fin), 128'd0);
    chk({tag, "_v_fin"}, 128'(v_fin), 128'd0);
    chk({tag, "_iter_cnt"}, 128'(iter_cnt), 128'd0);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_out_valid"}, 128'(out_valid), 128'd0);
  endtask

  // Scoreboard: compare on each accepted result handshake.
  always @(negedge clk) begin
    if (!arst && enable && out_valid && out_ready) begin
      n_checks++;
      assert (exp_q.size() > 0) else begin
        n_errors++;
        $error("FAIL sb_unexpected: observed result u=%0h with empty queue expected none", u_fin);
      end
      if (exp_q.size() > 0) begin
        res_t r;
        r = exp_q.pop_front();
        chk("sb_u_fin", 128'(u_fin), 128'(r.u));
        chk("sb_v_fin", 128'(v_fin), 128'(r.v));
        chk("sb_iter_cnt", 128'(iter_cnt), 128'(r.cnt));
      end
    end
  end

  initial begin
    int cyc;
    int bcnt;
    int seen;

    arst = 1'b1; enable = 1'b1; abort = 1'b0; start = 1'b0; out_ready = 1'b1;
    u_0 = '0; v_0 = '0; fixed_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    arst = 1'b0;
    step();

    // Basic operation with out_ready held high.
    start = 1'b1; u_0 = 64'd100; v_0 = 64'd200;
    push(64'd132, 64'd168, 7'd32);
    step();
    start = 1'b0;
    chk("t1_busy_after_start", 128'(busy), 128'd1);
    chk("t1_cs_n_start", 128'(cs_n), 128'd0);
    chk("t1_cs_u_n_load", 128'(cs_u_n), 128'd100);
    chk("t1_cs_v_n_load", 128'(cs_v_n), 128'd200);
    wait_valid(cyc, bcnt);
    chk("t1_latency", 128'(cyc), 128'd32);
    chk("t1_busy_cycles", 128'(bcnt), 128'd32);
    chk("t1_busy_in_done", 128'(busy), 128'd0);
    step();
    chk("t1_valid_cleared", 128'(out_valid), 128'd0);
    step();

    // Stall on out_ready, with ignored start pulses in ITER and DONE.
    out_ready = 1'b0;
    start = 1'b1; u_0 = 64'd100; v_0 = 64'd200;
    push(64'd132, 64'd168, 7'd32);
    step();
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0); u_0 = 64'd999; v_0 = 64'd999;
      step();
    end
    start = 1'b0;
    wait_valid(cyc, bcnt);
    chk("t2_latency", 128'(cyc), 128'd27);
    for (int i = 0; i < 10; i++) begin
      start = 1'b1; u_0 = 64'd7; v_0 = 64'd7;
      step();
      chk("t2_stall_valid", 128'(out_valid), 128'd1);
      chk("t2_stall_u_fin", 128'(u_fin), 128'd132);
      chk("t2_stall_v_fin", 128'(v_fin), 128'd168);
    end
    start = 1'b0; out_ready = 1'b1;
    step();
    chk("t2_release_valid", 128'(out_valid), 128'd0);
    step();
    chk("t2_idle_busy", 128'(busy), 128'd0);

    // Back-to-back operations.
    start = 1'b1; u_0 = 64'd0; v_0 = 64'd0;
    push(64'd32, 64'd0 - 64'd32, 7'd32);
    step();
    u_0 = 64'd5; v_0 = 64'd5;
    push(64'd37, 64'd5 - 64'd32, 7'd32);
    wait_valid(cyc, bcnt);
    chk("t3_first_latency", 128'(cyc), 128'd32);
    step();
    start = 1'b0;
    chk("t3_reload_busy", 128'(busy), 128'd1);
    chk("t3_reload_cs_u_n", 128'(cs_u_n), 128'd5);
    wait_valid(cyc, bcnt);
    chk("t3_second_spacing", 128'(cyc + 1), 128'd33);
    step();
    step();

    // Abort at cs_n=7 together with start.
    start = 1'b1; u_0 = 64'd100; v_0 = 64'd200;
    step();
    start = 1'b0;
    repeat (7) step();
    chk("t4_cs_n_before_abort", 128'(cs_n), 128'd7);
    abort = 1'b1; start = 1'b1; u_0 = 64'd55;
    step();
    abort = 1'b0; start = 1'b0;
    chk("t4_abort_busy", 128'(busy), 128'd0);
    chk("t4_abort_valid", 128'(out_valid), 128'd0);
    chk("t4_abort_cs_n", 128'(cs_n), 128'd0);
    chk("t4_abort_keeps_u_fin", 128'(u_fin), 128'd37);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid || busy) seen++;
    end
    chk("t4_no_activity", 128'(seen), 128'd0);
    start = 1'b1; u_0 = 64'd10; v_0 = 64'd20;
    push(64'd42, 64'd20 - 64'd32, 7'd32);
    step();
    start = 1'b0;
    wait_valid(cyc, bcnt);
    chk("t4_restart_latency", 128'(cyc), 128'd32);
    step();
    step();

    // Enable low for 5 cycles mid-ITER.
    start = 1'b1; u_0 = 64'd100; v_0 = 64'd200;
    push(64'd132, 64'd168, 7'd32);
    step();
    start = 1'b0;
    repeat (10) step();
    enable = 1'b0;
    repeat (5) step();
    chk("t5_frozen_cs_n", 128'(cs_n), 128'd10);
    chk("t5_frozen_cs_u_n", 128'(cs_u_n), 128'd110);
    enable = 1'b1;
    wait_valid(cyc, bcnt);
    chk("t5_delayed_latency", 128'(cyc + 15), 128'd37);
    step();
    step();

    // Asynchronous reset pulse at cs_n=20.
    start = 1'b1; u_0 = 64'd100; v_0 = 64'd200;
    step();
    start = 1'b0;
    repeat (20) step();
    chk("t6_cs_n_before_arst", 128'(cs_n), 128'd20);
    #2;
    arst = 1'b1;
    #1;
    chk_reset_vals("t6_arst");
    arst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen++;
    end
    chk("t6_no_result", 128'(seen), 128'd0);

    // Fixed-point datapath: early exit when enabled, full length otherwise.
    fixed_mode = 1'b1;
    start = 1'b1; u_0 = 64'd100; v_0 = 64'd200;
`ifdef BKM_SEQ_EARLY_EXIT_EN
    push(64'd103, 64'd197, 7'd4);
`else
    push(64'd103, 64'd197, 7'd32);
`endif
    step();
    start = 1'b0;
    wait_valid(cyc, bcnt);
`ifdef BKM_SEQ_EARLY_EXIT_EN
    chk("t7_early_latency", 128'(cyc), 128'd4);
`else
    chk("t7_full_latency", 128'(cyc), 128'd32);
`endif
    step();
    step();
    fixed_mode = 1'b0;

    chk("sb_drained", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
